// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   REG_ADDR_W : register address width
//   DEF_WIDTH  : default register data width
//   CNT_W      : width of the load starvation counter
//   arb_state_e: arbiter FSM states
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic {
    ALU_PRIO = 1'b0,
    LD_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the ALU/load requesters and the arbiter.
//   alu_valid/alu_rd/alu_data/alu_ready : ALU writeback handshake
//   ld_valid/ld_rd/ld_data/ld_ready     : load-unit writeback handshake
//   rf_we/rf_ad/rf_wd                   : registered register-file write port
//   ld_forced                           : arbiter is forcing a load grant
// master = requester side, slave = arbiter side.
interface wb_arbiter_if import wb_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [WIDTH-1:0]      alu_data;
  logic                  alu_ready;

  logic                  ld_valid;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [WIDTH-1:0]      ld_data;
  logic                  ld_ready;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_ad;
  logic [WIDTH-1:0]      rf_wd;
  logic                  ld_forced;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, rf_we, rf_ad, rf_wd, ld_forced
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, rf_we, rf_ad, rf_wd, ld_forced
  );

endinterface

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter. The ALU has priority; a load request
// denied MAX_WAIT consecutive cycles gets a forced grant (LD_FORCE).
// Accepted requests are written to rf_we/rf_ad/rf_wd one cycle later.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : writeback interface (slave side)
module wb_arbiter import wb_pkg::*; #(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  arb_state_e            state, state_next;
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_next;
  logic                  alu_acc, ld_acc;
  logic [REG_ADDR_W-1:0] rd_mux;
  logic [WIDTH-1:0]      wd_mux;

  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_ad_q;
  logic [WIDTH-1:0]      rf_wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ALU_PRIO;
      wait_cnt <= '0;
      rf_we_q  <= 1'b0;
      rf_ad_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      // rd==0 is accepted but never written
      rf_we_q  <= (alu_acc || ld_acc) && (rd_mux != '0);
      if (alu_acc || ld_acc) begin
        rf_ad_q <= rd_mux;
        rf_wd_q <= wd_mux;
      end
    end
  end

  always_comb begin
    alu_acc       = 1'b0;
    ld_acc        = 1'b0;
    state_next    = state;
    wait_cnt_next = wait_cnt;
    rd_mux        = bus.alu_rd;
    wd_mux        = bus.alu_data;

    // Grants are gated by rst_n so nothing is accepted while in reset.
    unique case (state)
      ALU_PRIO: begin
        alu_acc = rst_n && bus.alu_valid;
        ld_acc  = rst_n && bus.ld_valid && !bus.alu_valid;
      end
      LD_FORCE: begin
        ld_acc  = rst_n && bus.ld_valid;
        alu_acc = rst_n && bus.alu_valid && !bus.ld_valid;
      end
      default: ;
    endcase

    if (ld_acc) begin
      rd_mux = bus.ld_rd;
      wd_mux = bus.ld_data;
    end

    if (!bus.ld_valid || ld_acc) wait_cnt_next = '0;
    else                         wait_cnt_next = wait_cnt + 1'b1;

    unique case (state)
      ALU_PRIO: if (bus.ld_valid && !ld_acc && wait_cnt == WAIT_LAST) state_next = LD_FORCE;
      LD_FORCE: if (ld_acc || !bus.ld_valid) state_next = ALU_PRIO;
      default:  state_next = ALU_PRIO;
    endcase
  end

  assign bus.alu_ready = alu_acc;
  assign bus.ld_ready  = ld_acc;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_ad     = rf_ad_q;
  assign bus.rf_wd     = rf_wd_q;
  assign bus.ld_forced = (state == LD_FORCE);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (WIDTH=32, MAX_WAIT=4).
// Inputs are driven on the falling edge; ready/ld_forced are sampled
// shortly after, register-file outputs #1 after the rising edge.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  wb_arbiter_if #(.WIDTH(32)) bus ();

  wb_arbiter #(.WIDTH(32), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adat;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ldat;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requesters active
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("rst_ld_ready",  32'(bus.ld_ready),  32'd0);
    check("rst_rf_we",     32'(bus.rf_we),     32'd0);
    check("rst_rf_ad",     32'(bus.rf_ad),     32'd0);
    check("rst_rf_wd",     bus.rf_wd,          32'd0);
    check("rst_ld_forced", 32'(bus.ld_forced), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("rel_ld_ready",  32'(bus.ld_ready),  32'd0);
    @(posedge clk); #1;
    check("rel_rf_we", 32'(bus.rf_we), 32'd1);
    check("rel_rf_ad", 32'(bus.rf_ad), 32'd3);
    check("rel_rf_wd", bus.rf_wd,      32'h1111_1111);

    // Idle cycle: no accept, write port holds address/data
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    check("idle_rf_we", 32'(bus.rf_we), 32'd0);
    check("idle_rf_ad", 32'(bus.rf_ad), 32'd3);
    check("idle_rf_wd", bus.rf_wd,      32'h1111_1111);

    // ALU only
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    #1;
    check("alu_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("alu_ld_ready",  32'(bus.ld_ready),  32'd0);
    @(posedge clk); #1;
    check("alu_rf_we", 32'(bus.rf_we), 32'd1);
    check("alu_rf_ad", 32'(bus.rf_ad), 32'd5);
    check("alu_rf_wd", bus.rf_wd,      32'hDEAD_BEEF);

    // Starvation: ALU cycles 0-3, forced load cycle 4, ALU again cycle 5
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd1, 32'hA0 + 32'(c), 1'b1, 5'd2, 32'hB0);
      #1;
      check($sformatf("stv%0d_alu_ready", c), 32'(bus.alu_ready), (c == 4) ? 32'd0 : 32'd1);
      check($sformatf("stv%0d_ld_ready", c),  32'(bus.ld_ready),  (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("stv%0d_ld_forced", c), 32'(bus.ld_forced), (c == 4) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      check($sformatf("stv%0d_rf_we", c), 32'(bus.rf_we), 32'd1);
      check($sformatf("stv%0d_rf_ad", c), 32'(bus.rf_ad), (c == 4) ? 32'd2 : 32'd1);
      check($sformatf("stv%0d_rf_wd", c), bus.rf_wd,      (c == 4) ? 32'hB0 : 32'hA0 + 32'(c));
    end

    // Load to rd 0: accepted, not written, address/data still update
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    #1;
    check("rd0_ld_ready",  32'(bus.ld_ready),  32'd1);
    check("rd0_alu_ready", 32'(bus.alu_ready), 32'd0);
    @(posedge clk); #1;
    check("rd0_rf_we", 32'(bus.rf_we), 32'd0);
    check("rd0_rf_ad", 32'(bus.rf_ad), 32'd0);
    check("rd0_rf_wd", bus.rf_wd,      32'h1234);

    // Load drops after 2 denials; re-request needs 4 fresh denials
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd7, 32'hC0, 1'b1, 5'd8, 32'hD0);
      #1;
      check($sformatf("drp%0d_ld_ready", c), 32'(bus.ld_ready), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    drive(1'b1, 5'd7, 32'hC0, 1'b0, 5'd8, 32'hD0);
    #1;
    check("drp_gap_alu_ready", 32'(bus.alu_ready), 32'd1);
    @(posedge clk); #1;
    check("drp_gap_ld_forced", 32'(bus.ld_forced), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd7, 32'hC0, 1'b1, 5'd8, 32'hD0);
      #1;
      check($sformatf("rrq%0d_ld_ready", c),  32'(bus.ld_ready),  (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("rrq%0d_ld_forced", c), 32'(bus.ld_forced), (c == 4) ? 32'd1 : 32'd0);
      @(posedge clk);
    end

    // Async reset while in LD_FORCE
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd9, 32'hE0, 1'b1, 5'd10, 32'hF0);
      @(posedge clk);
    end
    @(negedge clk); #1;
    check("ar_ld_forced_pre", 32'(bus.ld_forced), 32'd1);
    check("ar_rf_we_pre",     32'(bus.rf_we),     32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_ld_forced", 32'(bus.ld_forced), 32'd0);
    check("ar_rf_we",     32'(bus.rf_we),     32'd0);
    check("ar_ld_ready",  32'(bus.ld_ready),  32'd0);
    check("ar_alu_ready", 32'(bus.alu_ready), 32'd0);
    @(posedge clk); #1;
    check("ar_hold_rf_we", 32'(bus.rf_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ar_rel_alu_ready", 32'(bus.alu_ready), 32'd1);
    @(posedge clk); #1;
    check("ar_rel_rf_ad", 32'(bus.rf_ad), 32'd9);
    check("ar_rel_rf_we", 32'(bus.rf_we), 32'd1);

    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
